// File: rtl/sram_bank_param.sv
// Simple-dual-port memory bank with byte-enable writes, configurable read latency
// and a hardware zero-fill sequencer that reports busy and illegal requests.
module sram_bank_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_start,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W:0]     clr_cnt;
  logic                clr_we;
  logic                idle;
  logic                wr_in_range;
  logic                rd_in_range;
  logic                wr_fire;
  logic                rd_fire;
  logic                err_nxt;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [RD_LAT-1:0]   vld_pipe;
  logic [DATA_W-1:0]   dat_pipe [RD_LAT];

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_C;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_C;
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign rd_idx      = rd_addr[IDX_W-1:0];
  assign wr_fire     = idle && wr_en && wr_in_range;
  assign rd_fire     = idle && rd_en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start)        state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == LAST_C) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A reset edge during CLEAR must not zero one more word.
  always_comb begin
    idle   = (state == IDLE);
    busy   = (state == CLEAR);
    clr_we = (state == CLEAR) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst)                    clr_cnt <= '0;
    else if (idle && clr_start) clr_cnt <= '0;
    else if (busy)              clr_cnt <= clr_cnt + 1'b1;
  end

  // NOTE: the array has no reset; contents survive rst and only the clear sequencer zeroes them.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt[IDX_W-1:0]] <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Stage 0 reads the pre-write word (read-first); later stages only move on valid so
  // the output register holds its last result between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= rd_fire;
      if (rd_fire) dat_pipe[0] <= rd_in_range ? mem[rd_idx] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign rd_data  = dat_pipe[RD_LAT-1];
  assign rd_valid = vld_pipe[RD_LAT-1];

  always_comb begin
    if (busy) err_nxt = wr_en || rd_en;
    else      err_nxt = (wr_en && !wr_in_range) || (rd_en && !rd_in_range);
  end

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= err_nxt;
  end

endmodule

// File: tb/tb_sram_bank_param.sv
// Bench for sram_bank_param: a small 64-word RD_LAT=1 bank and a default-size RD_LAT=3 bank,
// with a read scoreboard that checks data, order and exact arrival cycle.
module tb_sram_bank_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Bank A: 64 words behind an 8-bit address so out-of-range requests are reachable.
  logic        rst_a, a_clr_start, a_busy, a_wr_en, a_rd_en, a_rd_valid, a_err;
  logic [7:0]  a_wr_addr, a_rd_addr;
  logic [31:0] a_wr_data, a_rd_data;
  logic [3:0]  a_wr_be;

  // Bank B: default geometry with three-cycle read latency.
  logic        rst_b, b_clr_start, b_busy, b_wr_en, b_rd_en, b_rd_valid, b_err;
  logic [13:0] b_wr_addr, b_rd_addr;
  logic [31:0] b_wr_data, b_rd_data;
  logic [3:0]  b_wr_be;

  sram_bank_param #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst_a), .clr_start(a_clr_start), .busy(a_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .err(a_err)
  );

  sram_bank_param #(.DATA_W(32), .ADDR_W(14), .DEPTH(16384), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst_b), .clr_start(b_clr_start), .busy(b_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .err(b_err)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } sb_t;

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [7:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  sb_t  q_a[$];
  sb_t  q_b[$];
  sb_t  e_a, e_b;
  vec_t vecs[21];
  int   n;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboards: each rd_valid must match the oldest outstanding read, on its due cycle.
  always @(negedge clk) begin
    if (a_rd_valid) begin
      if (q_a.size() == 0) check("a_spurious_valid", a_rd_valid, 1'b0);
      else begin
        e_a = q_a.pop_front();
        check("a_rd_data", a_rd_data, e_a.data);
        check("a_rd_cycle", cyc, e_a.due);
      end
    end else if (q_a.size() != 0 && q_a[0].due <= cyc) begin
      check("a_rd_valid_due", a_rd_valid, 1'b1);
      void'(q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (b_rd_valid) begin
      if (q_b.size() == 0) check("b_spurious_valid", b_rd_valid, 1'b0);
      else begin
        e_b = q_b.pop_front();
        check("b_rd_data", b_rd_data, e_b.data);
        check("b_rd_cycle", cyc, e_b.due);
      end
    end else if (q_b.size() != 0 && q_b[0].due <= cyc) begin
      check("b_rd_valid_due", b_rd_valid, 1'b1);
      void'(q_b.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_quiet();
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_wr_be = '0;
    a_rd_en = 1'b0; a_rd_addr = '0; a_clr_start = 1'b0;
  endtask

  task automatic a_fill(input logic [31:0] val);
    for (int w = 0; w < 64; w++) begin
      a_wr_en = 1'b1; a_wr_addr = 8'(w); a_wr_data = val; a_wr_be = 4'hF;
      step();
    end
    a_quiet();
  endtask

  task automatic a_read(input logic [7:0] addr, input logic [31:0] exp);
    a_rd_en = 1'b1; a_rd_addr = addr;
    q_a.push_back('{exp, cyc + 1});
    step();
    a_rd_en = 1'b0;
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 8'h05, 32'hDEAD_BEEF, 4'hF, 1'b0, 8'h00, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h05, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 8'h10, 32'h1122_3344, 4'hF, 1'b0, 8'h00, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 8'h10, 32'hAABB_CCDD, 4'h5, 1'b0, 8'h00, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h10, 32'h11BB_33DD, 1'b0};
    vecs[5]  = '{1'b1, 8'h20, 32'h0000_0001, 4'hF, 1'b0, 8'h00, 32'h0,         1'b0};
    vecs[6]  = '{1'b1, 8'h20, 32'h0000_0002, 4'hF, 1'b1, 8'h20, 32'h0000_0001, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h20, 32'h0000_0002, 1'b0};
    vecs[8]  = '{1'b1, 8'h21, 32'h1234_5678, 4'hF, 1'b0, 8'h00, 32'h0,         1'b0};
    vecs[9]  = '{1'b1, 8'h21, 32'hFFFF_FFFF, 4'h0, 1'b0, 8'h00, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h21, 32'h1234_5678, 1'b0};
    vecs[11] = '{1'b1, 8'h00, 32'h0000_0000, 4'hF, 1'b0, 8'h00, 32'h0,         1'b0};
    vecs[12] = '{1'b1, 8'h80, 32'hFFFF_FFFF, 4'hF, 1'b0, 8'h00, 32'h0,         1'b1};
    vecs[13] = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h00, 32'h0000_0000, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'hC0, 32'h0000_0000, 1'b1};
    vecs[15] = '{1'b1, 8'h3F, 32'hCAFE_F00D, 4'hF, 1'b0, 8'h00, 32'h0,         1'b0};
    vecs[16] = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h3F, 32'hCAFE_F00D, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h40, 32'h0000_0000, 1'b1};
    vecs[18] = '{1'b1, 8'h40, 32'h5555_5555, 4'hF, 1'b0, 8'h00, 32'h0,         1'b1};
    vecs[19] = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h00, 32'h0000_0000, 1'b0};
    vecs[20] = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h3F, 32'hCAFE_F00D, 1'b0};

    rst_a = 1'b1; rst_b = 1'b1;
    a_quiet();
    b_clr_start = 1'b0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_be = '0;
    b_rd_en = 1'b0; b_rd_addr = '0;
    repeat (3) step();

    check("a_rst_rd_data", a_rd_data, 32'h0);
    check("a_rst_rd_valid", a_rd_valid, 1'b0);
    check("a_rst_busy", a_busy, 1'b0);
    check("a_rst_err", a_err, 1'b0);
    check("b_rst_rd_data", b_rd_data, 32'h0);
    check("b_rst_rd_valid", b_rd_valid, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;
    step();

    // Vector table on bank A: writes, byte lanes, read-first, range edges.
    foreach (vecs[i]) begin
      a_wr_en = vecs[i].we; a_wr_addr = vecs[i].wa; a_wr_data = vecs[i].wd; a_wr_be = vecs[i].be;
      a_rd_en = vecs[i].re; a_rd_addr = vecs[i].ra;
      if (vecs[i].re) q_a.push_back('{vecs[i].exp_rd, cyc + 1});
      step();
      check($sformatf("a_err_vec%0d", i), a_err, vecs[i].exp_err);
    end
    a_quiet();
    repeat (2) step();
    check("a_hold_valid", a_rd_valid, 1'b0);
    check("a_hold_data", a_rd_data, 32'hCAFE_F00D);

    // Full clear with a read in the start cycle and illegal requests while busy.
    a_fill(32'hFFFF_FFFF);
    a_clr_start = 1'b1;
    a_read(8'h03, 32'hFFFF_FFFF);
    a_clr_start = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 200) begin
      n++;
      a_wr_en = (n == 20); a_wr_addr = 8'h05; a_wr_data = 32'h1234_5678; a_wr_be = 4'hF;
      a_rd_en = (n == 22); a_rd_addr = 8'h06;
      a_clr_start = (n == 25);
      step();
      if (n == 20 || n == 22) check($sformatf("a_err_busy%0d", n), a_err, 1'b1);
      if (n == 21 || n == 25) check($sformatf("a_err_quiet%0d", n), a_err, 1'b0);
    end
    a_quiet();
    check("a_busy_cycles", n, 64);
    for (int w = 0; w < 64; w++) a_read(8'(w), 32'h0);
    repeat (3) step();

    // Reset on the 10th busy cycle aborts the clear.
    a_fill(32'hFFFF_FFFF);
    a_clr_start = 1'b1;
    step();
    a_clr_start = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 200) begin
      n++;
      if (n == 10) rst_a = 1'b1;
      step();
      if (n == 10) begin
        rst_a = 1'b0;
        check("a_busy_after_rst", a_busy, 1'b0);
        check("a_valid_after_rst", a_rd_valid, 1'b0);
        break;
      end
    end
    check("a_rst_busy_count", n, 10);
    for (int w = 0; w < 9; w++) a_read(8'(w), 32'h0);
    a_read(8'd40, 32'hFFFF_FFFF);
    repeat (3) step();

    // Bank B: eight pipelined reads, one result per cycle three cycles after issue.
    for (int w = 0; w < 8; w++) begin
      b_wr_en = 1'b1; b_wr_addr = 14'(w); b_wr_data = 32'hB000_0000 + 32'(w) * 32'h0101; b_wr_be = 4'hF;
      step();
    end
    b_wr_en = 1'b0;
    for (int w = 0; w < 8; w++) begin
      b_rd_en = 1'b1; b_rd_addr = 14'(w);
      q_b.push_back('{32'hB000_0000 + 32'(w) * 32'h0101, cyc + 3});
      step();
    end
    b_rd_en = 1'b0;
    repeat (5) step();

    // Reads still in the pipe when rst hits must never appear.
    b_rd_en = 1'b1; b_rd_addr = 14'd1;
    step();
    b_rd_addr = 14'd2;
    step();
    b_rd_en = 1'b0; rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    check("b_data_after_rst", b_rd_data, 32'h0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("b_no_stale%0d", k), b_rd_valid, 1'b0);
      step();
    end

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_bank_param.md
Name: sram_bank_param

Overview:
- Parametrised simple-dual-port on-chip memory bank for weight, activation and image storage in the MNIST accelerator.
- Successor of the fixed 16K x 32 single-port memory. Adds:
  - separate read and write ports, usable in the same cycle;
  - byte-enable writes;
  - configurable read latency with a matching valid pipeline;
  - a hardware zero-fill (clear) sequencer with busy/error reporting.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 14, address width in bits.
- DEPTH, 16384, number of words; must satisfy DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles from rd_en to rd_valid; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- clr_start  in  1  one-cycle pulse; starts a zero-fill of the whole array
- busy  out  1  high while a zero-fill is in progress
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_be  in  DATA_W/8  byte enables; bit i enables wr_data[8i+7:8i]
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data is valid this cycle
- err  out  1  one-cycle pulse flagging an illegal request

Behaviour:
- Reset values:
  - rd_data = 0, rd_valid = 0, busy = 0, err = 0.
  - The read pipeline is flushed and the FSM goes to IDLE.
  - Array contents are not reset.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_start = 1. busy rises the next cycle. The clear counter is loaded with 0.
  - CLEAR: writes all-zero words at clr_cnt, one word per cycle; clr_cnt increments each cycle.
  - After the word at DEPTH-1 is written, CLEAR -> IDLE. busy falls the following cycle.
  - busy is therefore high for exactly DEPTH cycles.
  - clr_start while in CLEAR is ignored, with no err.
- Writes (IDLE only):
  - With wr_en = 1, each byte lane whose wr_be bit is 1 is updated at the clock edge; other lanes keep their contents.
  - wr_be = 0 performs no write and raises no error.
- Reads (IDLE only):
  - With rd_en = 1, the word at rd_addr is captured; rd_data and rd_valid appear exactly RD_LAT cycles later.
  - Back-to-back reads are fully pipelined, one result per cycle.
  - rd_data holds its last value when rd_valid = 0.
- Read-during-write, same address, same cycle: read-first. The read returns the pre-write word; the new data is visible to reads issued on the next cycle or later.
- Out-of-range addresses (addr >= DEPTH):
  - A write is dropped; a read produces rd_valid with rd_data = 0.
  - err pulses 1 cycle after the request.
  - Not reachable when DEPTH = 2**ADDR_W.
- Requests during CLEAR:
  - wr_en or rd_en while busy = 1 is dropped; no rd_valid is produced.
  - err pulses 1 cycle later, once per offending cycle.
- clr_start in the same cycle as wr_en/rd_en while IDLE: the access completes normally, then the clear begins.
- Reset during CLEAR: the sequence aborts and busy = 0 the next cycle. Words already zeroed stay zero; the remaining words are untouched.
- Reads in flight across a reset are discarded; no rd_valid is produced.
- clr_cnt is ADDR_W+1 bits wide so it cannot wrap before reaching DEPTH.

Test Plan:
- Basic R/W, RD_LAT = 1: write 0xDEADBEEF @ 0x0005 with wr_be = 4'hF; read 0x0005 next cycle -> rd_valid high 1 cycle later with rd_data = 0xDEADBEEF.
- Byte enables: preload 0x11223344 @ 0x10; write 0xAABBCCDD with wr_be = 4'b0101 -> read returns 0x11BB33DD.
- Read-first collision: mem[0x20] = 0x1; same cycle, write 0x2 @ 0x20 and read 0x20 -> 0x1; the read on the next cycle -> 0x2.
- Latency/pipeline, RD_LAT = 3: reads of addresses 0..7 on consecutive cycles -> rd_valid high for 8 consecutive cycles starting 3 cycles after the first rd_en, data in issue order.
- Clear, DEPTH = 64: fill with 0xFFFFFFFF, pulse clr_start -> busy high exactly 64 cycles. A write issued mid-clear yields an err pulse and is dropped. All 64 words then read back 0.
- Reset mid-clear, DEPTH = 64: assert rst on the 10th busy cycle -> busy = 0 next cycle. Words 0..8 read 0; word 40 still reads 0xFFFFFFFF. No stale rd_valid after reset.
